// File: rtl/mem_stage_if.sv
// Bus bundle between the EX stage, the MEM stage, the data memory and WB.
// The slave modport is the MEM stage's view; the master modport is the
// surrounding pipeline/memory view that drives EX_* and DM_rdata/DM_ack.
interface mem_stage_if;
  // EX -> MEM
  logic        EX_valid;
  logic [0:1]  EX_op;
  logic [0:4]  EX_rD;
  logic [0:4]  EX_PPPWW;
  logic [0:63] EX_result;
  logic [0:31] EX_addr;
  // MEM -> EX
  logic        MEM_stall;
  // MEM <-> data memory
  logic        DM_req;
  logic        DM_we;
  logic [0:31] DM_addr;
  logic [0:63] DM_wdata;
  logic [0:63] DM_rdata;
  logic        DM_ack;
  // MEM -> WB
  logic        WB_en;
  logic [0:4]  WB_rD;
  logic [0:4]  WB_PPPWW;
  logic [0:63] WB_data;
  logic        MEM_err;

  modport slave (
    input  EX_valid, EX_op, EX_rD, EX_PPPWW, EX_result, EX_addr,
    input  DM_rdata, DM_ack,
    output MEM_stall, DM_req, DM_we, DM_addr, DM_wdata,
    output WB_en, WB_rD, WB_PPPWW, WB_data, MEM_err
  );

  modport master (
    output EX_valid, EX_op, EX_rD, EX_PPPWW, EX_result, EX_addr,
    output DM_rdata, DM_ack,
    input  MEM_stall, DM_req, DM_we, DM_addr, DM_wdata,
    input  WB_en, WB_rD, WB_PPPWW, WB_data, MEM_err
  );
endinterface

// File: rtl/mem_stage.sv
// Pipeline MEM stage: ALU results pass straight to write-back in one cycle,
// loads/stores issue a single memory request and stall EX until the memory
// acknowledges or TIMEOUT cycles pass without an acknowledge.
module mem_stage #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  mem_stage_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_LD = 2'd1,
    WAIT_ST = 2'd2
  } state_e;

  localparam logic [1:0] OP_ALU   = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;

  // Counter value of the last waiting cycle before the access is abandoned.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_e      state_q;
  logic [7:0]  cnt_q;
  logic        dm_req_q;
  logic        dm_we_q;
  logic [31:0] dm_addr_q;
  logic [63:0] dm_wdata_q;
  logic [4:0]  ld_rd_q;
  logic [4:0]  ld_pppww_q;
  logic        wb_en_q;
  logic [4:0]  wb_rd_q;
  logic [4:0]  wb_pppww_q;
  logic [63:0] wb_data_q;
  logic        mem_err_q;

  // Stall comes from the state register alone so DM_ack never reaches EX
  // combinationally.
  assign bus.MEM_stall = (state_q != IDLE);
  assign bus.DM_req    = dm_req_q;
  assign bus.DM_we     = dm_we_q;
  assign bus.DM_addr   = dm_addr_q;
  assign bus.DM_wdata  = dm_wdata_q;
  assign bus.WB_en     = wb_en_q;
  assign bus.WB_rD     = wb_rd_q;
  assign bus.WB_PPPWW  = wb_pppww_q;
  assign bus.WB_data   = wb_data_q;
  assign bus.MEM_err   = mem_err_q;

  // Stage FSM with registered memory-bus and write-back outputs.
  // NOTE: the reset branch is asynchronous so an access in flight is
  // dropped the moment rst rises, without waiting for a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      dm_req_q   <= 1'b0;
      dm_we_q    <= 1'b0;
      dm_addr_q  <= '0;
      dm_wdata_q <= '0;
      ld_rd_q    <= '0;
      ld_pppww_q <= '0;
      wb_en_q    <= 1'b0;
      wb_rd_q    <= '0;
      wb_pppww_q <= '0;
      wb_data_q  <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch below
      // sees the pre-edge values of the registers it reads.
      wb_en_q   <= 1'b0;
      mem_err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.EX_valid) begin
            case (bus.EX_op)
              OP_ALU: begin
                // Writes to r0 are discarded; WB fields keep their values.
                if (bus.EX_rD != 5'd0) begin
                  wb_en_q    <= 1'b1;
                  wb_rd_q    <= bus.EX_rD;
                  wb_pppww_q <= bus.EX_PPPWW;
                  wb_data_q  <= bus.EX_result;
                end
              end
              OP_LOAD: begin
                dm_req_q   <= 1'b1;
                dm_we_q    <= 1'b0;
                dm_addr_q  <= bus.EX_addr;
                ld_rd_q    <= bus.EX_rD;
                ld_pppww_q <= bus.EX_PPPWW;
                cnt_q      <= '0;
                state_q    <= WAIT_LD;
              end
              OP_STORE: begin
                dm_req_q   <= 1'b1;
                dm_we_q    <= 1'b1;
                dm_addr_q  <= bus.EX_addr;
                dm_wdata_q <= bus.EX_result;
                cnt_q      <= '0;
                state_q    <= WAIT_ST;
              end
              default: ;
            endcase
          end
        end
        WAIT_LD, WAIT_ST: begin
          // An acknowledge takes priority over the timeout in the same cycle.
          if (bus.DM_ack) begin
            dm_req_q <= 1'b0;
            dm_we_q  <= 1'b0;
            cnt_q    <= '0;
            state_q  <= IDLE;
            if (state_q == WAIT_LD && ld_rd_q != 5'd0) begin
              wb_en_q    <= 1'b1;
              wb_rd_q    <= ld_rd_q;
              wb_pppww_q <= ld_pppww_q;
              wb_data_q  <= bus.DM_rdata;
            end
          end else if (cnt_q == CNT_LAST) begin
            dm_req_q  <= 1'b0;
            dm_we_q   <= 1'b0;
            cnt_q     <= '0;
            mem_err_q <= 1'b1;
            state_q   <= IDLE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a table of single-cycle vectors followed by
// hand-written timeout, reset-abort and back-to-back sequences.
module tb_mem_stage;

  localparam int TIMEOUT = 15;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  mem_stage_if bus ();

  mem_stage #(.TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    // inputs
    logic        valid;
    logic [1:0]  op;
    logic [4:0]  rd;
    logic [4:0]  pppww;
    logic [63:0] result;
    logic [31:0] addr;
    logic        ack;
    logic [63:0] rdata;
    // expected outputs after the edge
    logic        stall;
    logic        req;
    logic        we;
    logic [31:0] daddr;
    logic [63:0] wdata;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [4:0]  wb_pppww;
    logic [63:0] wb_data;
    logic        err;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic valid, input logic [1:0] op, input logic [4:0] rd,
                       input logic [4:0] pppww, input logic [63:0] result,
                       input logic [31:0] addr, input logic ack, input logic [63:0] rdata);
    bus.EX_valid  = valid;
    bus.EX_op     = op;
    bus.EX_rD     = rd;
    bus.EX_PPPWW  = pppww;
    bus.EX_result = result;
    bus.EX_addr   = addr;
    bus.DM_ack    = ack;
    bus.DM_rdata  = rdata;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_stall"},    64'(bus.MEM_stall), 64'd0);
    check({tag, "_req"},      64'(bus.DM_req),    64'd0);
    check({tag, "_we"},       64'(bus.DM_we),     64'd0);
    check({tag, "_addr"},     64'(bus.DM_addr),   64'd0);
    check({tag, "_wdata"},    64'(bus.DM_wdata),  64'd0);
    check({tag, "_wb_en"},    64'(bus.WB_en),     64'd0);
    check({tag, "_wb_rd"},    64'(bus.WB_rD),     64'd0);
    check({tag, "_wb_pppww"}, 64'(bus.WB_PPPWW),  64'd0);
    check({tag, "_wb_data"},  64'(bus.WB_data),   64'd0);
    check({tag, "_err"},      64'(bus.MEM_err),   64'd0);
  endtask

  localparam logic [63:0] D1 = 64'h0123456789ABCDEF;
  localparam logic [63:0] DL = 64'hFFFF0000FFFF0000;
  localparam logic [63:0] DF = 64'hFFFFFFFFFFFFFFFF;

  initial begin
    int pulses;
    int req_cycles;
    n_vec = 0;
    n_err = 0;

    //            valid op  rd  ppp    result   addr     ack rdata      stall req we daddr    wdata   wb rd  ppp    wb_data err
    vecs[0]  = '{0, 2'd0, 5'd0,  5'h00, 64'h0,    32'h0,   0, 64'h0,     0, 0, 0, 32'h0,   64'h0,  0, 5'd0,  5'h00, 64'h0, 0};
    vecs[1]  = '{1, 2'd0, 5'd5,  5'h00, D1,       32'h0,   0, 64'h0,     0, 0, 0, 32'h0,   64'h0,  1, 5'd5,  5'h00, D1,    0};
    vecs[2]  = '{1, 2'd3, 5'd9,  5'h1F, 64'h1,    32'h10,  0, 64'h0,     0, 0, 0, 32'h0,   64'h0,  0, 5'd5,  5'h00, D1,    0};
    vecs[3]  = '{0, 2'd0, 5'd3,  5'h00, 64'h2,    32'h0,   0, 64'h0,     0, 0, 0, 32'h0,   64'h0,  0, 5'd5,  5'h00, D1,    0};
    vecs[4]  = '{0, 2'd0, 5'd0,  5'h00, 64'h0,    32'h0,   1, 64'h77,    0, 0, 0, 32'h0,   64'h0,  0, 5'd5,  5'h00, D1,    0};
    vecs[5]  = '{1, 2'd1, 5'd7,  5'h15, 64'h9,    32'h40,  0, 64'h0,     1, 1, 0, 32'h40,  64'h0,  0, 5'd5,  5'h00, D1,    0};
    vecs[6]  = '{1, 2'd0, 5'd4,  5'h00, 64'h3,    32'h99,  0, 64'h0,     1, 1, 0, 32'h40,  64'h0,  0, 5'd5,  5'h00, D1,    0};
    vecs[7]  = '{1, 2'd2, 5'd4,  5'h00, 64'h3,    32'h98,  0, 64'h0,     1, 1, 0, 32'h40,  64'h0,  0, 5'd5,  5'h00, D1,    0};
    vecs[8]  = '{0, 2'd0, 5'd0,  5'h00, 64'h0,    32'h0,   1, DL,        0, 0, 0, 32'h40,  64'h0,  1, 5'd7,  5'h15, DL,    0};
    vecs[9]  = '{1, 2'd2, 5'd0,  5'h00, 64'hAA,   32'h80,  0, 64'h0,     1, 1, 1, 32'h80,  64'hAA, 0, 5'd7,  5'h15, DL,    0};
    vecs[10] = '{1, 2'd2, 5'd0,  5'h00, 64'hAA,   32'h80,  0, 64'h0,     1, 1, 1, 32'h80,  64'hAA, 0, 5'd7,  5'h15, DL,    0};
    vecs[11] = '{0, 2'd0, 5'd0,  5'h00, 64'h0,    32'h0,   1, 64'h5,     0, 0, 0, 32'h80,  64'hAA, 0, 5'd7,  5'h15, DL,    0};
    vecs[12] = '{1, 2'd0, 5'd0,  5'h03, 64'h1234, 32'h0,   0, 64'h0,     0, 0, 0, 32'h0,   64'h0,  0, 5'd7,  5'h15, DL,    0};
    vecs[13] = '{1, 2'd1, 5'd0,  5'h02, 64'h0,    32'h44,  0, 64'h0,     1, 1, 0, 32'h44,  64'h0,  0, 5'd7,  5'h15, DL,    0};
    vecs[14] = '{0, 2'd0, 5'd0,  5'h00, 64'h0,    32'h0,   1, 64'h5555,  0, 0, 0, 32'h44,  64'h0,  0, 5'd7,  5'h15, DL,    0};
    vecs[15] = '{1, 2'd0, 5'd31, 5'h1F, DF,       32'h0,   0, 64'h0,     0, 0, 0, 32'h0,   64'h0,  1, 5'd31, 5'h1F, DF,    0};
    vecs[16] = '{1, 2'd0, 5'd2,  5'h01, 64'hDEAD, 32'h0,   0, 64'h0,     0, 0, 0, 32'h0,   64'h0,  1, 5'd2,  5'h01, 64'hDEAD, 0};

    // Reset state, checked before any clock edge.
    rst = 1'b1;
    drive(0, 2'd0, 5'd0, 5'd0, 64'h0, 32'h0, 0, 64'h0);
    #3;
    check_all_zero("reset");
    step();
    step();
    rst = 1'b0;

    // Table of single-cycle vectors.
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].valid, vecs[i].op, vecs[i].rd, vecs[i].pppww,
            vecs[i].result, vecs[i].addr, vecs[i].ack, vecs[i].rdata);
      step();
      check($sformatf("v%0d_stall", i),    64'(bus.MEM_stall), 64'(vecs[i].stall));
      check($sformatf("v%0d_req", i),      64'(bus.DM_req),    64'(vecs[i].req));
      check($sformatf("v%0d_we", i),       64'(bus.DM_we),     64'(vecs[i].we));
      if (vecs[i].req)
        check($sformatf("v%0d_addr", i),   64'(bus.DM_addr),   64'(vecs[i].daddr));
      if (vecs[i].we)
        check($sformatf("v%0d_wdata", i),  64'(bus.DM_wdata),  vecs[i].wdata);
      check($sformatf("v%0d_wb_en", i),    64'(bus.WB_en),     64'(vecs[i].wb_en));
      check($sformatf("v%0d_wb_rd", i),    64'(bus.WB_rD),     64'(vecs[i].wb_rd));
      check($sformatf("v%0d_wb_pppww", i), 64'(bus.WB_PPPWW),  64'(vecs[i].wb_pppww));
      check($sformatf("v%0d_wb_data", i),  64'(bus.WB_data),   vecs[i].wb_data);
      check($sformatf("v%0d_err", i),      64'(bus.MEM_err),   64'(vecs[i].err));
    end

    // Timeout: load with no acknowledge, request held exactly TIMEOUT cycles.
    drive(1, 2'd1, 5'd9, 5'h04, 64'h0, 32'h100, 0, 64'h0);
    step();
    check("to_req_start", 64'(bus.DM_req), 64'd1);
    drive(0, 2'd0, 5'd0, 5'd0, 64'h0, 32'h0, 0, 64'h0);
    req_cycles = 1;
    for (int k = 1; k < TIMEOUT; k++) begin
      step();
      if (bus.DM_req) req_cycles++;
      check($sformatf("to_err_early%0d", k), 64'(bus.MEM_err), 64'd0);
    end
    step();
    check("to_req_drop", 64'(bus.DM_req),    64'd0);
    check("to_err",      64'(bus.MEM_err),   64'd1);
    check("to_wb_en",    64'(bus.WB_en),     64'd0);
    check("to_stall",    64'(bus.MEM_stall), 64'd0);
    check("to_req_cycles", 64'(req_cycles),  64'(TIMEOUT));
    step();
    check("to_err_pulse", 64'(bus.MEM_err),  64'd0);

    // Acknowledge on the last waiting cycle wins over the timeout.
    drive(1, 2'd1, 5'd10, 5'h06, 64'h0, 32'h104, 0, 64'h0);
    step();
    drive(0, 2'd0, 5'd0, 5'd0, 64'h0, 32'h0, 0, 64'h0);
    for (int k = 1; k < TIMEOUT; k++) step();
    check("late_req_held", 64'(bus.DM_req), 64'd1);
    drive(0, 2'd0, 5'd0, 5'd0, 64'h0, 32'h0, 1, 64'hCAFE);
    step();
    check("late_wb_en",    64'(bus.WB_en),    64'd1);
    check("late_wb_rd",    64'(bus.WB_rD),    64'd10);
    check("late_wb_pppww", 64'(bus.WB_PPPWW), 64'h06);
    check("late_wb_data",  64'(bus.WB_data),  64'hCAFE);
    check("late_err",      64'(bus.MEM_err),  64'd0);
    check("late_req",      64'(bus.DM_req),   64'd0);

    // Reset while waiting on a load: outputs clear at once, no write-back.
    drive(1, 2'd1, 5'd12, 5'h07, 64'h0, 32'h200, 0, 64'h0);
    step();
    drive(0, 2'd0, 5'd0, 5'd0, 64'h0, 32'h0, 0, 64'h0);
    step();
    check("rst_pre_req", 64'(bus.DM_req), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("rst_mid");
    drive(0, 2'd0, 5'd0, 5'd0, 64'h0, 32'h0, 1, 64'h1);
    step();
    check("rst_ack_wb_en", 64'(bus.WB_en), 64'd0);
    rst = 1'b0;
    drive(1, 2'd0, 5'd3, 5'h02, 64'h33, 32'h0, 1, 64'h1);
    step();
    check("rst_first_wb_en",   64'(bus.WB_en),   64'd1);
    check("rst_first_wb_rd",   64'(bus.WB_rD),   64'd3);
    check("rst_first_wb_data", 64'(bus.WB_data), 64'h33);
    check("rst_first_err",     64'(bus.MEM_err), 64'd0);

    // Eight back-to-back ALU ops, rD = 0..7.
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1, 2'd0, 5'(i), 5'h00, 64'(i) * 64'h1111, 32'h0, 0, 64'h0);
      step();
      if (bus.WB_en) pulses++;
      check($sformatf("b2b%0d_wb_en", i), 64'(bus.WB_en), 64'(i != 0));
      check($sformatf("b2b%0d_stall", i), 64'(bus.MEM_stall), 64'd0);
      if (i != 0) begin
        check($sformatf("b2b%0d_wb_rd", i),   64'(bus.WB_rD),   64'(i));
        check($sformatf("b2b%0d_wb_data", i), 64'(bus.WB_data), 64'(i) * 64'h1111);
      end
    end
    check("b2b_pulses", 64'(pulses), 64'd7);
    drive(0, 2'd0, 5'd0, 5'd0, 64'h0, 32'h0, 0, 64'h0);
    step();
    check("b2b_idle_wb_en", 64'(bus.WB_en), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
